// File: rtl/mem_bist_sp_if.sv
// -----------------------------------------------------------------------------
// mem_bist_sp_if
// Single-port RAM bus between the BIST engine and the RAM wrapper.
//   master : BIST side, drives the command and write data, receives read data.
//   slave  : RAM side, receives the command and returns read data.
// Signals:
//   mem_ce    chip enable
//   mem_we    write enable (qualified by mem_ce)
//   mem_addr  word address
//   mem_wdata write data
//   mem_rdata read data, valid READ_LATENCY cycles after a read command
// -----------------------------------------------------------------------------
interface mem_bist_sp_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 8
) ();
    logic              mem_ce;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_ce,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata
    );

    modport slave (
        input  mem_ce,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/mem_bist_sp.sv
// -----------------------------------------------------------------------------
// mem_bist_sp
// Built-in self-test engine for one single-port RAM. On a start pulse it writes
// a pattern over the whole address space, reads it back and compares, once per
// pattern (pattern 0 = address replicated, pattern 1 = its inverse).
//
// Ports:
//   clock, reset   system clock, synchronous active-high reset
//   start          request, sampled only while idle or done
//   busy           test in progress
//   done           test complete, held until next start or reset
//   pass           valid with done; 1 = no miscompare
//   err_count      saturating miscompare count
//   fail_valid     first-failure capture valid
//   fail_addr      address of the first miscompare
//   fail_pattern   pattern index of the first miscompare
//   mem            RAM bus (master modport)
//
// Optional build macro MEM_BIST_HALT_ON_FAIL_EN: when defined the first
// miscompare ends the test immediately (pass=0, err_count=1).
// -----------------------------------------------------------------------------
module mem_bist_sp #(
    parameter int ADDR_W       = 11,
    parameter int DATA_W       = 8,
    parameter int READ_LATENCY = 1,
    parameter int NUM_PATTERNS = 2,
    parameter int ERR_W        = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERR_W-1:0]  err_count,
    output logic              fail_valid,
    output logic [ADDR_W-1:0] fail_addr,
    output logic              fail_pattern,
    mem_bist_sp_if.master     mem
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
    localparam logic [ERR_W-1:0]  ERR_MAX   = '1;
    localparam int                DRAIN_W   = $clog2(READ_LATENCY + 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(READ_LATENCY - 1);
    localparam logic              LAST_PAT  = 1'(NUM_PATTERNS - 1);

    typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

    state_t             state, state_next;
    logic [ADDR_W-1:0]  addr, addr_next;
    logic               pat, pat_next;
    logic [DRAIN_W-1:0] drain_cnt, drain_next;
    logic               flush;

    logic [ERR_W-1:0]   err_next;
    logic               fail_valid_next;
    logic [ADDR_W-1:0]  fail_addr_next;
    logic               fail_pattern_next;

    logic [READ_LATENCY-1:0] pipe_valid;
    logic [DATA_W-1:0]       pipe_exp  [READ_LATENCY];
    logic [ADDR_W-1:0]       pipe_addr [READ_LATENCY];
    logic                    pipe_pat  [READ_LATENCY];

    logic miscompare;
    logic start_ok;

    // Address bits repeated as often as needed to fill the data word.
    function automatic logic [DATA_W-1:0] pattern_data(input logic [ADDR_W-1:0] a,
                                                       input logic p);
        logic [DATA_W-1:0] d;
        for (int i = 0; i < DATA_W; i++) begin
            d[i] = a[i % ADDR_W];
        end
        return p ? ~d : d;
    endfunction

    // The last pipeline stage lines up with the RAM output for its read.
    assign miscompare = pipe_valid[READ_LATENCY-1] &&
                        (mem.mem_rdata != pipe_exp[READ_LATENCY-1]);
    assign start_ok   = start && (state == IDLE || state == DONE);

    always_comb begin
        state_next = state;
        addr_next  = addr;
        pat_next   = pat;
        drain_next = drain_cnt;
        flush      = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_next = WRITE;
                    addr_next  = '0;
                    pat_next   = 1'b0;
                end
            end
            WRITE: begin
                if (addr == LAST_ADDR) begin
                    state_next = READ;
                    addr_next  = '0;
                end else begin
                    addr_next = addr + 1'b1;
                end
            end
            READ: begin
                if (addr == LAST_ADDR) begin
                    state_next = DRAIN;
                    addr_next  = '0;
                    drain_next = '0;
                end else begin
                    addr_next = addr + 1'b1;
                end
            end
            DRAIN: begin
                if (drain_cnt == DRAIN_LAST) begin
                    if (pat == LAST_PAT) begin
                        state_next = DONE;
                    end else begin
                        state_next = WRITE;
                        pat_next   = 1'b1;
                    end
                end else begin
                    drain_next = drain_cnt + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
`ifdef MEM_BIST_HALT_ON_FAIL_EN
        // First miscompare abandons the run; reads still in flight are dropped.
        if (miscompare && !fail_valid) begin
            state_next = DONE;
            flush      = 1'b1;
        end
`endif
    end

    // Result bookkeeping: cleared by an accepted start, otherwise updated by
    // each compare. The pipeline is always empty while idle or done.
    always_comb begin
        err_next          = err_count;
        fail_valid_next   = fail_valid;
        fail_addr_next    = fail_addr;
        fail_pattern_next = fail_pattern;
        if (start_ok) begin
            err_next          = '0;
            fail_valid_next   = 1'b0;
            fail_addr_next    = '0;
            fail_pattern_next = 1'b0;
        end else if (miscompare) begin
            if (err_count != ERR_MAX) begin
                err_next = err_count + 1'b1;
            end
            if (!fail_valid) begin
                fail_valid_next   = 1'b1;
                fail_addr_next    = pipe_addr[READ_LATENCY-1];
                fail_pattern_next = pipe_pat[READ_LATENCY-1];
            end
        end
    end

    // Outputs are registered from next-state values so the RAM command and
    // status flags line up with the state they belong to.
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            addr          <= '0;
            pat           <= 1'b0;
            drain_cnt     <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            err_count     <= '0;
            fail_valid    <= 1'b0;
            fail_addr     <= '0;
            fail_pattern  <= 1'b0;
            mem.mem_ce    <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
            pipe_valid    <= '0;
        end else begin
            state         <= state_next;
            addr          <= addr_next;
            pat           <= pat_next;
            drain_cnt     <= drain_next;
            busy          <= (state_next == WRITE) || (state_next == READ) ||
                             (state_next == DRAIN);
            done          <= (state_next == DONE);
            pass          <= (state_next == DONE) && (err_next == '0);
            err_count     <= err_next;
            fail_valid    <= fail_valid_next;
            fail_addr     <= fail_addr_next;
            fail_pattern  <= fail_pattern_next;
            mem.mem_ce    <= (state_next == WRITE) || (state_next == READ);
            mem.mem_we    <= (state_next == WRITE);
            mem.mem_addr  <= addr_next;
            mem.mem_wdata <= (state_next == WRITE) ? pattern_data(addr_next, pat_next) : '0;

            for (int i = READ_LATENCY - 1; i > 0; i--) begin
                pipe_valid[i] <= pipe_valid[i-1] && !flush;
                pipe_exp[i]   <= pipe_exp[i-1];
                pipe_addr[i]  <= pipe_addr[i-1];
                pipe_pat[i]   <= pipe_pat[i-1];
            end
            pipe_valid[0] <= (state == READ) && !flush;
            pipe_exp[0]   <= pattern_data(addr, pat);
            pipe_addr[0]  <= addr;
            pipe_pat[0]   <= pat;
        end
    end

endmodule

// File: tb/tb_mem_bist_sp.sv
// -----------------------------------------------------------------------------
// tb_mem_bist_sp
// Self-checking bench for mem_bist_sp. Three engines share clock and reset:
//   unit 1: ADDR_W=4, DATA_W=8, READ_LATENCY=1, ERR_W=16
//   unit 2: same but READ_LATENCY=2 with a registered-output RAM model
//   unit 3: same as unit 1 but ERR_W=2
// RAM fault modes: 0 ideal, 1 bit0 of addr 5 stuck at 1,
//                  2 address bit3 ignored, 3 unit 2 RAM answers one cycle early.
// -----------------------------------------------------------------------------
module tb_mem_bist_sp;

    localparam int AW = 4;
    localparam int DW = 8;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic start_req = 1'b0;
    int   cur_unit = 1;
    int   fault = 0;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clock = ~clock;

    logic start1, start2, start3;
    assign start1 = start_req && (cur_unit == 1);
    assign start2 = start_req && (cur_unit == 2);
    assign start3 = start_req && (cur_unit == 3);

    logic          busy1, done1, pass1, fv1, fp1;
    logic [15:0]   err1;
    logic [AW-1:0] fa1;
    logic          busy2, done2, pass2, fv2, fp2;
    logic [15:0]   err2;
    logic [AW-1:0] fa2;
    logic          busy3, done3, pass3, fv3, fp3;
    logic [1:0]    err3;
    logic [AW-1:0] fa3;

    mem_bist_sp_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();
    mem_bist_sp_if #(.ADDR_W(AW), .DATA_W(DW)) bus2 ();
    mem_bist_sp_if #(.ADDR_W(AW), .DATA_W(DW)) bus3 ();

    mem_bist_sp #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(1), .NUM_PATTERNS(2), .ERR_W(16)) dut1 (
        .clock(clock), .reset(reset), .start(start1), .busy(busy1), .done(done1),
        .pass(pass1), .err_count(err1), .fail_valid(fv1), .fail_addr(fa1),
        .fail_pattern(fp1), .mem(bus1));

    mem_bist_sp #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(2), .NUM_PATTERNS(2), .ERR_W(16)) dut2 (
        .clock(clock), .reset(reset), .start(start2), .busy(busy2), .done(done2),
        .pass(pass2), .err_count(err2), .fail_valid(fv2), .fail_addr(fa2),
        .fail_pattern(fp2), .mem(bus2));

    mem_bist_sp #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(1), .NUM_PATTERNS(2), .ERR_W(2)) dut3 (
        .clock(clock), .reset(reset), .start(start3), .busy(busy3), .done(done3),
        .pass(pass3), .err_count(err3), .fail_valid(fv3), .fail_addr(fa3),
        .fail_pattern(fp3), .mem(bus3));

    // RAM models
    logic [DW-1:0] ram1 [16];
    logic [DW-1:0] ram2 [16];
    logic [DW-1:0] ram3 [16];
    logic [DW-1:0] rd2_q1, rd2_q2;

    function automatic logic [AW-1:0] eff_addr(input logic [AW-1:0] a);
        return (fault == 2) ? {1'b0, a[2:0]} : a;
    endfunction

    function automatic logic [DW-1:0] rd_fault(input logic [AW-1:0] a, input logic [DW-1:0] d);
        return (fault == 1 && a == 4'd5) ? (d | 8'h01) : d;
    endfunction

    always @(posedge clock) begin
        if (bus1.mem_ce) begin
            if (bus1.mem_we) ram1[eff_addr(bus1.mem_addr)] <= bus1.mem_wdata;
            else bus1.mem_rdata <= rd_fault(bus1.mem_addr, ram1[eff_addr(bus1.mem_addr)]);
        end
        if (bus3.mem_ce) begin
            if (bus3.mem_we) ram3[eff_addr(bus3.mem_addr)] <= bus3.mem_wdata;
            else bus3.mem_rdata <= rd_fault(bus3.mem_addr, ram3[eff_addr(bus3.mem_addr)]);
        end
        if (bus2.mem_ce) begin
            if (bus2.mem_we) ram2[eff_addr(bus2.mem_addr)] <= bus2.mem_wdata;
            else rd2_q1 <= rd_fault(bus2.mem_addr, ram2[eff_addr(bus2.mem_addr)]);
        end
        rd2_q2 <= rd2_q1;
    end

    assign bus2.mem_rdata = (fault == 3) ? rd2_q1 : rd2_q2;

    // Observation mux for the unit under test
    logic        busy_m, done_m, pass_m, fv_m, fp_m, ce_m;
    logic [31:0] err_m, fa_m;

    always_comb begin
        busy_m = busy1; done_m = done1; pass_m = pass1; fv_m = fv1; fp_m = fp1;
        ce_m = bus1.mem_ce; err_m = 32'(err1); fa_m = 32'(fa1);
        case (cur_unit)
            2: begin
                busy_m = busy2; done_m = done2; pass_m = pass2; fv_m = fv2; fp_m = fp2;
                ce_m = bus2.mem_ce; err_m = 32'(err2); fa_m = 32'(fa2);
            end
            3: begin
                busy_m = busy3; done_m = done3; pass_m = pass3; fv_m = fv3; fp_m = fp3;
                ce_m = bus3.mem_ce; err_m = 32'(err3); fa_m = 32'(fa3);
            end
            default: ;
        endcase
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Pulse start on one unit, then count cycles with busy high (bounded).
    task automatic applyStimulus(input int unit, input int f, output int cycles);
        @(negedge clock);
        cur_unit  = unit;
        fault     = f;
        start_req = 1'b1;
        @(negedge clock);
        start_req = 1'b0;
        cycles = 0;
        while (busy_m === 1'b1 && cycles < 2000) begin
            cycles++;
            @(negedge clock);
        end
    endtask

    typedef struct {
        int    unit;
        int    fault;
        int    exp_busy;
        bit    exp_pass;
        int    exp_err;
        bit    exp_fv;
        int    exp_fa;
        bit    exp_fp;
        string name;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int cycles;

        vecs[0] = '{1, 0, 66, 1'b1, 0,  1'b0, 0, 1'b0, "u1_ideal"};
        vecs[3] = '{2, 0, 68, 1'b1, 0,  1'b0, 0, 1'b0, "u2_lat2_ideal"};
`ifdef MEM_BIST_HALT_ON_FAIL_EN
        vecs[1] = '{1, 1, 56, 1'b0, 1,  1'b1, 5, 1'b1, "u1_stuck"};
        vecs[2] = '{1, 2, 18, 1'b0, 1,  1'b1, 0, 1'b0, "u1_alias"};
        vecs[4] = '{2, 3, 19, 1'b0, 1,  1'b1, 0, 1'b0, "u2_wrong_lat"};
        vecs[5] = '{3, 2, 18, 1'b0, 1,  1'b1, 0, 1'b0, "u3_alias_errw2"};
`else
        vecs[1] = '{1, 1, 66, 1'b0, 1,  1'b1, 5, 1'b1, "u1_stuck"};
        vecs[2] = '{1, 2, 66, 1'b0, 16, 1'b1, 0, 1'b0, "u1_alias"};
        vecs[4] = '{2, 3, 68, 1'b0, 30, 1'b1, 0, 1'b0, "u2_wrong_lat"};
        vecs[5] = '{3, 2, 66, 1'b0, 3,  1'b1, 0, 1'b0, "u3_alias_errw2"};
`endif

        // Reset state
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        checkOutput("reset_busy", 32'(busy_m), 0);
        checkOutput("reset_done", 32'(done_m), 0);
        checkOutput("reset_pass", 32'(pass_m), 0);
        checkOutput("reset_err", err_m, 0);
        checkOutput("reset_fail_valid", 32'(fv_m), 0);
        checkOutput("reset_mem_ce", 32'(ce_m), 0);

        // Table-driven full runs
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].unit, vecs[i].fault, cycles);
            checkOutput({vecs[i].name, "_busy_cycles"}, 32'(cycles), 32'(vecs[i].exp_busy));
            checkOutput({vecs[i].name, "_done"}, 32'(done_m), 1);
            checkOutput({vecs[i].name, "_pass"}, 32'(pass_m), 32'(vecs[i].exp_pass));
            checkOutput({vecs[i].name, "_err"}, err_m, 32'(vecs[i].exp_err));
            checkOutput({vecs[i].name, "_fail_valid"}, 32'(fv_m), 32'(vecs[i].exp_fv));
            checkOutput({vecs[i].name, "_fail_addr"}, fa_m, 32'(vecs[i].exp_fa));
            checkOutput({vecs[i].name, "_fail_pattern"}, 32'(fp_m), 32'(vecs[i].exp_fp));
            checkOutput({vecs[i].name, "_mem_ce_done"}, 32'(ce_m), 0);
        end

        // start pulsed again while busy is ignored
        @(negedge clock);
        cur_unit = 1; fault = 0; start_req = 1'b1;
        @(negedge clock);
        start_req = 1'b0;
        cycles = 0;
        while (busy_m === 1'b1 && cycles < 2000) begin
            cycles++;
            start_req = (cycles == 10);
            @(negedge clock);
        end
        start_req = 1'b0;
        checkOutput("restart_busy_cycles", 32'(cycles), 66);
        checkOutput("restart_pass", 32'(pass_m), 1);

        // start in DONE clears previous failing results and reruns
        applyStimulus(1, 1, cycles);
        checkOutput("prefail_pass", 32'(pass_m), 0);
        @(negedge clock);
        fault = 0; start_req = 1'b1;
        @(negedge clock);
        start_req = 1'b0;
        checkOutput("rerun_busy", 32'(busy_m), 1);
        checkOutput("rerun_done_cleared", 32'(done_m), 0);
        checkOutput("rerun_err_cleared", err_m, 0);
        checkOutput("rerun_fail_valid_cleared", 32'(fv_m), 0);
        cycles = 0;
        while (busy_m === 1'b1 && cycles < 2000) begin
            cycles++;
            @(negedge clock);
        end
        checkOutput("rerun_busy_cycles", 32'(cycles), 66);
        checkOutput("rerun_pass", 32'(pass_m), 1);

        // Reset 20 cycles into a test aborts it
        @(negedge clock);
        fault = 2; start_req = 1'b1;
        @(negedge clock);
        start_req = 1'b0;
        repeat (19) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checkOutput("abort_busy", 32'(busy_m), 0);
        checkOutput("abort_mem_ce", 32'(ce_m), 0);
        checkOutput("abort_err", err_m, 0);
        checkOutput("abort_done", 32'(done_m), 0);
        applyStimulus(1, 0, cycles);
        checkOutput("after_abort_busy_cycles", 32'(cycles), 66);
        checkOutput("after_abort_pass", 32'(pass_m), 1);

        // start coincident with reset: reset wins
        @(negedge clock);
        reset = 1'b1; start_req = 1'b1;
        @(negedge clock);
        reset = 1'b0; start_req = 1'b0;
        checkOutput("start_with_reset_busy", 32'(busy_m), 0);
        checkOutput("start_with_reset_done", 32'(done_m), 0);
        @(negedge clock);
        checkOutput("start_with_reset_busy_later", 32'(busy_m), 0);
        checkOutput("start_with_reset_mem_ce", 32'(ce_m), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
